fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS core.
// Holds the PC, drives the instruction-memory word address and owns the
// IF/ID pipeline register feeding the decoder.
//
// Configuration macro: DELAY_SLOT_EN
//   defined   - the delay-slot instruction after a redirect executes
//   undefined - the delay-slot instruction is annulled (instr_d <= 0)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   stall        in   freeze PC and IF/ID this cycle
//   redirect     in   control-flow change taken this cycle
//   redirect_pc  in   redirect target, bits [1:0] ignored
//   imem_addr    out  word index into instruction memory
//   imem_rdata   in   instruction word at imem_addr (combinational read)
//   pc_f         out  current fetch PC
//   instr_d      out  IF/ID instruction
//   pc_d         out  PC of instr_d
//   pc8_d        out  pc_d + 8, jal link value
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc_f,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc8_d
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_f_q,    pc_f_d;
    logic [XLEN-1:0] instr_d_q, instr_d_d;
    logic [XLEN-1:0] pc_d_q,    pc_d_d;
    logic [XLEN-1:0] pc8_d_q,   pc8_d_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus8;
    logic [XLEN-1:0] pc_off;
    logic [XLEN-1:0] redirect_aligned;

    // Modulo-2^32 sequential and link addresses.
    assign pc_plus4         = pc_f_q + XLEN'(4);
    assign pc_plus8         = pc_f_q + XLEN'(8);
    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Word offset from the memory base; out-of-window PCs wrap naturally.
    assign pc_off    = pc_f_q - PC_RESET;
    assign imem_addr = ADDR_W'(pc_off >> 2);

    // Next-state selection: stall > redirect > sequential (reset in the register).
    always_comb begin
        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pc8_d_d   = pc8_d_q;
        if (!stall) begin
            pc_d_d    = pc_f_q;
            pc8_d_d   = pc_plus8;
            instr_d_d = imem_rdata;
            if (redirect) begin
                pc_f_d = redirect_aligned;
`ifndef DELAY_SLOT_EN
                // Annul the delay slot: a zero word decodes as a NOP.
                instr_d_d = '0;
`endif
            end else begin
                pc_f_d = pc_plus4;
            end
        end
    end

    // PC and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= '0;
            pc_d_q    <= '0;
            pc8_d_q   <= '0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            pc8_d_q   <= pc8_d_d;
        end
    end

    assign pc_f    = pc_f_q;
    assign instr_d = instr_d_q;
    assign pc_d    = pc_d_q;
    assign pc8_d   = pc8_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: behavioural instruction memory, a reference
// model pushing expected IF/ID state into a scoreboard queue, and scenario
// tasks comparing DUT outputs against popped entries and fixed values.
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc8;
        logic [9:0]  addr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;

    logic [31:0] mem [1024];
    exp_t        sb [$];

    int n_checks;
    int n_pass;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc8_d      (pc8_d)
    );

    assign imem_rdata = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] word_of(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - BASE;
        return off[11:2];
    endfunction

    // Drive one cycle of inputs, advance the model, push the expectation,
    // then step past the clock edge.
    task automatic drive(input logic r, input logic s, input logic rd,
                         input logic [31:0] tgt);
        exp_t e;
        logic [31:0] w;
        reset = r; stall = s; redirect = rd; redirect_pc = tgt;
        if (r) begin
            m_pc = BASE; m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0;
        end else if (!s) begin
            w = mem[word_of(m_pc)];
`ifdef DELAY_SLOT_EN
            m_instr = w;
`else
            m_instr = rd ? 32'h0 : w;
`endif
            m_pcd = m_pc;
            m_pc8 = m_pc + 32'd8;
            m_pc  = rd ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc8 = m_pc8;
        e.addr = word_of(m_pc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        e = sb.pop_front();
        n_checks++;
        if ({pc_f, instr_d, pc_d, pc8_d} !== {e.pc, e.instr, e.pcd, e.pc8})
            $display("FAIL reset_sb: got %h/%h/%h/%h want %h/%h/%h/%h",
                     pc_f, instr_d, pc_d, pc8_d, e.pc, e.instr, e.pcd, e.pc8);
        else n_pass++;
        n_checks++;
        if (pc_f !== 32'h3000 || imem_addr !== 10'd0 || instr_d !== 32'h0 ||
            pc_d !== 32'h0 || pc8_d !== 32'h0)
            $display("FAIL reset_const: pc_f=%h addr=%0d instr=%h pc_d=%h pc8=%h want 3000/0/0/0/0",
                     pc_f, imem_addr, instr_d, pc_d, pc8_d);
        else n_pass++;
    endtask

    task automatic test_seq();
        exp_t e;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            e = sb.pop_front();
            n_checks++;
            if ({pc_f, instr_d, pc_d, pc8_d, imem_addr} !==
                {e.pc, e.instr, e.pcd, e.pc8, e.addr})
                $display("FAIL seq_sb[%0d]: got %h/%h/%h/%h/%0d want %h/%h/%h/%h/%0d", k,
                         pc_f, instr_d, pc_d, pc8_d, imem_addr,
                         e.pc, e.instr, e.pcd, e.pc8, e.addr);
            else n_pass++;
            n_checks++;
            if (pc_f !== BASE + 32'(4 * k) || imem_addr !== 10'(k) ||
                instr_d !== mem[k-1] || pc8_d !== pc_d + 32'd8)
                $display("FAIL seq_const[%0d]: pc_f=%h addr=%0d instr=%h pc8=%h want %h/%0d/%h/%h",
                         k, pc_f, imem_addr, instr_d, pc8_d,
                         BASE + 32'(4 * k), k, mem[k-1], pc_d + 32'd8);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            e = sb.pop_front();
            n_checks++;
            if (pc_f !== 32'h3010 || instr_d !== 32'hC0DE_0003 ||
                {pc_d, pc8_d} !== {e.pcd, e.pc8})
                $display("FAIL stall_hold[%0d]: pc_f=%h instr=%h pc_d=%h want 3010/c0de0003/%h",
                         k, pc_f, instr_d, pc_d, e.pcd);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3014 || instr_d !== 32'hC0DE_0004 || pc_d !== 32'h3010 ||
            instr_d !== e.instr)
            $display("FAIL stall_release: pc_f=%h instr=%h pc_d=%h want 3014/c0de0004/3010",
                     pc_f, instr_d, pc_d);
        else n_pass++;
    endtask

    task automatic test_redirect();
        exp_t e;
        logic [31:0] want_i;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) void'(sb.pop_front());
        n_checks++;
        if (pc_d !== 32'h3008 || pc_f !== 32'h300C)
            $display("FAIL redir_setup: pc_d=%h pc_f=%h want 3008/300c", pc_d, pc_f);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'h3020);
        e = sb.pop_front();
`ifdef DELAY_SLOT_EN
        want_i = 32'hC0DE_0003;
`else
        want_i = 32'h0;
`endif
        n_checks++;
        if (pc_f !== 32'h3020 || instr_d !== want_i || pc_d !== 32'h300C ||
            pc8_d !== 32'h3014 || imem_addr !== e.addr)
            $display("FAIL redir_taken: pc_f=%h instr=%h pc_d=%h pc8=%h want 3020/%h/300c/3014",
                     pc_f, instr_d, pc_d, pc8_d, want_i);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3024 || instr_d !== 32'hC0DE_0008 || pc_d !== e.pcd)
            $display("FAIL redir_target: pc_f=%h instr=%h pc_d=%h want 3024/c0de0008/%h",
                     pc_f, instr_d, pc_d, e.pcd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3000 || instr_d !== 32'h0 || pc_d !== 32'h0 ||
            pc8_d !== 32'h0 || pc_f !== e.pc)
            $display("FAIL reset_mid: pc_f=%h instr=%h pc_d=%h pc8=%h want 3000/0/0/0",
                     pc_f, instr_d, pc_d, pc8_d);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3004 || instr_d !== 32'hC0DE_0000 || pc_d !== 32'h3000 ||
            instr_d !== e.instr)
            $display("FAIL reset_first_fetch: pc_f=%h instr=%h pc_d=%h want 3004/c0de0000/3000",
                     pc_f, instr_d, pc_d);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h3040);
            e = sb.pop_front();
            n_checks++;
            if (pc_f !== 32'h3004 || pc_f !== e.pc || instr_d !== e.instr)
                $display("FAIL redir_stall_hold[%0d]: pc_f=%h instr=%h want 3004/%h",
                         k, pc_f, instr_d, e.instr);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 1'b1, 32'h3040);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3040 || pc_d !== 32'h3004 || {instr_d, pc8_d} !== {e.instr, e.pc8})
            $display("FAIL redir_stall_release: pc_f=%h pc_d=%h instr=%h want 3040/3004/%h",
                     pc_f, pc_d, instr_d, e.instr);
        else n_pass++;
    endtask

    task automatic test_align_wrap();
        exp_t e;
        drive(1'b0, 1'b0, 1'b1, 32'h3043);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h3040 || imem_addr !== 10'd16 || pc_f !== e.pc)
            $display("FAIL align: pc_f=%h addr=%0d want 3040/16", pc_f, imem_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, BASE + 32'd4096);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h4000 || imem_addr !== 10'd0 || imem_addr !== e.addr)
            $display("FAIL window_wrap: pc_f=%h addr=%0d want 4000/0", pc_f, imem_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (instr_d !== 32'hC0DE_0000 || pc_d !== 32'h4000 || pc_f !== 32'h4004 ||
            imem_addr !== 10'd1 || pc8_d !== e.pc8)
            $display("FAIL window_fetch: instr=%h pc_d=%h pc_f=%h addr=%0d want c0de0000/4000/4004/1",
                     instr_d, pc_d, pc_f, imem_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'hFFFF_FFFC || imem_addr !== 10'h3FF || imem_addr !== e.addr)
            $display("FAIL top_addr: pc_f=%h addr=%h want fffffffc/3ff", pc_f, imem_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (pc_f !== 32'h0 || pc_d !== 32'hFFFF_FFFC || pc8_d !== 32'h4 ||
            instr_d !== mem[1023] || instr_d !== e.instr)
            $display("FAIL pc_wrap32: pc_f=%h pc_d=%h pc8=%h instr=%h want 0/fffffffc/4/%h",
                     pc_f, pc_d, pc8_d, instr_d, mem[1023]);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_pc = BASE; m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0;

        test_reset();
        test_seq();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_redirect_stall();
        test_align_wrap();

        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
